dds_cmd_loader: RTL
===================

Name: dds_cmd_loader

Overview:
- Host-side writer for the DDS tuning interface.
- Parses a byte stream from the UART receiver into DDS commands: frequency load, output enable and output disable.
- Drives the DDS `m` word, `set` strobe and `en` line, and returns a one-byte acknowledge to the UART transmitter.
- Sits between uart_rx/uart_tx and the dds block in the icestick top level.

Parameters:
- SET_WIDTH, 4, number of clk cycles `set` is held high (≥1).
- TIMEOUT, 1200000, inter-byte timeout in clk cycles during payload (100 ms at 12 MHz); ≥2.
- M_RESET, 32'h0, tuning word driven after reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in the same cycle.
- tx_data  out  8  acknowledge byte.
- tx_valid  out  1  acknowledge valid; held until tx_ready.
- tx_ready  in  1  transmitter accepts tx_data when tx_valid&&tx_ready.
- m  out  32  tuning word to the DDS.
- set  out  1  load strobe to the DDS (rising edge latches m).
- en  out  1  DDS output enable.
- overrun  out  1  one-cycle pulse when a byte is dropped.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; m=M_RESET; set=0; en=0.
  - tx_valid=0; tx_data=0; overrun=0; counters=0.
  - Reset mid-command discards any partial payload. m keeps no partial value.
- Command bytes, accepted only in IDLE:
  - 0x46 'F': go to PAYLOAD; clear byte count and timeout counter.
  - 0x45 'E': en<=1 next cycle; queue ack 0x4B 'K'.
  - 0x44 'D': en<=0 next cycle; queue ack 'K'.
  - Any other byte: queue ack 0x3F '?'; en and m unchanged.
- PAYLOAD:
  - Accepts 4 bytes, big-endian, into a shadow register. The first byte is m[31:24].
  - Each accepted byte clears the timeout counter and increments the byte count.
  - m is NOT changed while bytes arrive. The DDS keeps its old word.
  - On the 4th byte: m<=shadow in the next cycle, then go to STROBE.
  - Timeout: the counter increments each cycle with no rx_valid. When it reaches TIMEOUT-1, drop the payload, keep m unchanged, queue ack 0x54 'T', go to ACK.
  - rx_valid in the same cycle as the timeout terminal count: the byte wins; no timeout.
- STROBE:
  - set=1 starts the cycle after m updates, so m is stable for ≥1 cycle before the rising edge.
  - set is held exactly SET_WIDTH cycles, then deasserts.
  - m is held constant through the strobe and until the next completed F command.
  - Then queue ack 'K' and go to ACK.
- ACK:
  - tx_valid=1 with tx_data = the queued byte. Hold both until tx_ready is sampled high; then tx_valid=0 and go to IDLE.
  - Handshake completing in the first ACK cycle is legal: 1-cycle ack.
- Overrun:
  - rx_valid in STROBE or ACK drops the byte and pulses overrun for 1 cycle. No state change.
- Latency:
  - 'E'/'D' byte to en change: 1 cycle.
  - 4th payload byte to m update: 1 cycle; to set rising: 2 cycles.
- Width rules:
  - The byte count is 2 bits, with no wrap past 3.
  - The timeout counter is sized $clog2(TIMEOUT) and saturates; it never wraps.
- State encoding: IDLE, PAYLOAD, STROBE, ACK.

Decomposition:
- Package dds_pkg:
  - Command byte constants: CMD_FREQ=8'h46, CMD_EN=8'h45, CMD_DIS=8'h44.
  - Ack constants: ACK_OK=8'h4B, ACK_BAD=8'h3F, ACK_TMO=8'h54.
  - State enum.
- Sub-module: one natural sub-module, dds_timeout_ctr — a saturating counter with clear and terminal-count output, reused for the set-width count.
- Everything else stays in one module.

Test Plan:
- Reset, then send 'E' → en=1 one cycle after rx_valid; tx_data=8'h4B with tx_valid; m=0, set=0 throughout.
- Send 0x46,0x12,0x34,0x56,0x78 → m=32'h12345678 one cycle after the last byte. set goes high 2 cycles after the last byte for 4 cycles. Ack 'K'. m is unchanged before the 4th byte.
- Send 0x46,0xAA,0xBB, then idle 1200000 cycles → m unchanged; set never asserts; ack 'T'; next 'D' gives en=0 and 'K'.
- Hold tx_ready=0 for 50 cycles during ACK and inject rx_valid twice → tx_valid/tx_data stable; overrun pulses twice; state returns to IDLE only after tx_ready=1.
- Send 0x7A → ack '?'; en and m unchanged. Then assert rst_n=0 mid-payload (after 2 bytes) → all outputs return to reset values immediately, asynchronously.
- Present rx_valid exactly on the timeout terminal cycle → byte accepted, no 'T'; the full word still loads correctly.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS command loader.
// Covers the host command bytes, the acknowledge bytes and the FSM state encoding.
package dds_pkg;

  localparam logic [7:0] CMD_FREQ = 8'h46;
  localparam logic [7:0] CMD_EN   = 8'h45;
  localparam logic [7:0] CMD_DIS  = 8'h44;

  localparam logic [7:0] ACK_OK  = 8'h4B;
  localparam logic [7:0] ACK_BAD = 8'h3F;
  localparam logic [7:0] ACK_TMO = 8'h54;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_STROBE,
    ST_ACK
  } state_t;

  // The payload is big-endian, so each new byte shifts in at the bottom.
  function automatic logic [31:0] shift_in(input logic [31:0] word, input logic [7:0] b);
    return {word[23:0], b};
  endfunction

endpackage

// File: rtl/dds_timeout_ctr.sv
// Saturating up-counter with synchronous clear and a terminal-count flag.
// Serves as the payload inter-byte timeout and as the set-strobe width counter.
module dds_timeout_ctr #(
  parameter int unsigned TC_VALUE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_tc
);

  localparam int unsigned W = (TC_VALUE < 1) ? 1 : $clog2(TC_VALUE + 1);

  logic [W-1:0] r_count;
  logic         w_tc;

  assign w_tc = (r_count == W'(TC_VALUE));
  assign o_tc = w_tc;

  // Holds at the terminal count instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && !w_tc) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/dds_cmd_loader.sv
// Turns the UART byte stream into DDS frequency loads and enable changes.
// It returns a one-byte acknowledge for each command.
module dds_cmd_loader
  import dds_pkg::*;
#(
  parameter int unsigned SET_WIDTH = 4,
  parameter int unsigned TIMEOUT   = 1200000,
  parameter logic [31:0] M_RESET   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] m,
  output logic        set,
  output logic        en,
  output logic        overrun
);

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_m;
  logic [31:0] w_nextM;
  logic [31:0] r_shadow;
  logic [31:0] w_nextShadow;
  logic [1:0]  r_byteCnt;
  logic [1:0]  w_nextByteCnt;
  logic        r_en;
  logic        w_nextEn;
  logic        r_set;
  logic        w_nextSet;
  logic [7:0]  r_ackByte;
  logic [7:0]  w_nextAckByte;
  logic        r_overrun;
  logic        w_nextOverrun;
  logic        w_tmoTc;
  logic        w_setTc;

  // Any received byte restarts the inter-byte timeout.
  dds_timeout_ctr #(
    .TC_VALUE(TIMEOUT - 1)
  ) u_tmoCtr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear((r_state != ST_PAYLOAD) || rx_valid),
    .i_inc  (1'b1),
    .o_tc   (w_tmoTc)
  );

  dds_timeout_ctr #(
    .TC_VALUE(SET_WIDTH)
  ) u_setCtr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(r_state != ST_STROBE),
    .i_inc  (1'b1),
    .o_tc   (w_setTc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m       <= M_RESET;
      r_shadow  <= '0;
      r_byteCnt <= '0;
      r_en      <= 1'b0;
      r_set     <= 1'b0;
      r_ackByte <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_m       <= w_nextM;
      r_shadow  <= w_nextShadow;
      r_byteCnt <= w_nextByteCnt;
      r_en      <= w_nextEn;
      r_set     <= w_nextSet;
      r_ackByte <= w_nextAckByte;
      r_overrun <= w_nextOverrun;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextM       = r_m;
    w_nextShadow  = r_shadow;
    w_nextByteCnt = r_byteCnt;
    w_nextEn      = r_en;
    w_nextSet     = 1'b0;
    w_nextAckByte = r_ackByte;
    w_nextOverrun = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (rx_valid) begin
          unique case (rx_data)
            CMD_FREQ: begin
              w_nextState   = ST_PAYLOAD;
              w_nextByteCnt = 2'd0;
              w_nextShadow  = '0;
            end
            CMD_EN: begin
              w_nextEn      = 1'b1;
              w_nextAckByte = ACK_OK;
              w_nextState   = ST_ACK;
            end
            CMD_DIS: begin
              w_nextEn      = 1'b0;
              w_nextAckByte = ACK_OK;
              w_nextState   = ST_ACK;
            end
            default: begin
              w_nextAckByte = ACK_BAD;
              w_nextState   = ST_ACK;
            end
          endcase
        end
      end
      // The live word only changes once all four bytes are in.
      ST_PAYLOAD: begin
        if (rx_valid) begin
          w_nextShadow = shift_in(r_shadow, rx_data);
          if (r_byteCnt == 2'd3) begin
            w_nextM       = shift_in(r_shadow, rx_data);
            w_nextByteCnt = 2'd0;
            w_nextState   = ST_STROBE;
          end else begin
            w_nextByteCnt = r_byteCnt + 2'd1;
          end
        end else if (w_tmoTc) begin
          w_nextByteCnt = 2'd0;
          w_nextAckByte = ACK_TMO;
          w_nextState   = ST_ACK;
        end
      end
      // The first STROBE cycle only lets m settle, so set rises one cycle later.
      ST_STROBE: begin
        w_nextOverrun = rx_valid;
        if (w_setTc) begin
          w_nextAckByte = ACK_OK;
          w_nextState   = ST_ACK;
        end else begin
          w_nextSet = 1'b1;
        end
      end
      ST_ACK: begin
        w_nextOverrun = rx_valid;
        if (tx_ready) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  assign tx_valid = (r_state == ST_ACK);
  assign tx_data  = (r_state == ST_ACK) ? r_ackByte : 8'h00;
  assign m        = r_m;
  assign set      = r_set;
  assign en       = r_en;
  assign overrun  = r_overrun;

endmodule
